// File: rtl/parking_exit_biller_pkg.sv
// Shared state encoding, width constants and default billing constants for the exit biller.
package parking_pkg;

  localparam int DEF_TIME_W      = 8;
  localparam int DEF_FEE_W       = 12;
  localparam int DEF_UNIT        = 15;
  localparam int DEF_RATE        = 2;
  localparam int DEF_FREE_TIME   = 10;
  localparam int DEF_MAX_FEE     = 30;
  localparam int DEF_GATE_CYCLES = 4;

  typedef enum logic [2:0] {
    IDLE,
    DIFF,
    DIV,
    MUL,
    PRESENT,
    GATE
  } state_t;

endpackage

// File: rtl/parking_exit_biller_if.sv
// Time-register inputs, payment handshake and gate/status outputs of the exit biller.
interface parking_exit_biller_if #(
  parameter int TIME_W = 8,
  parameter int FEE_W  = 12
);

  logic [TIME_W-1:0] data_P;
  logic [TIME_W-1:0] data_Q;
  logic              checkout;
  logic              pay_ack;
  logic [TIME_W-1:0] duration;
  logic [FEE_W-1:0]  fee;
  logic              fee_valid;
  logic              gate_open;
  logic              busy;

  // Handshake: fee_valid rises with fee already stable; both hold until pay_ack
  // is sampled high, and the transfer completes on that same edge.
  modport master (
    output data_P, data_Q, checkout, pay_ack,
    input  duration, fee, fee_valid, gate_open, busy
  );

  modport slave (
    input  data_P, data_Q, checkout, pay_ack,
    output duration, fee, fee_valid, gate_open, busy
  );

endinterface

// File: rtl/parking_exit_biller_fee_divider.sv
// Iterative ceiling divider: one subtraction of UNIT per cycle, quotient = ceil(dividend/UNIT).
module fee_divider #(
  parameter int TIME_W = 8,
  parameter int UNIT   = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              clear,
  input  logic [TIME_W-1:0] dividend,
  output logic [TIME_W-1:0] quotient,
  output logic              done
);

  logic [TIME_W-1:0] rem;
  logic              running;

  // done marks the final step, so the caller leaves on the edge that completes the quotient.
  assign done = running && (rem <= TIME_W'(UNIT));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rem      <= '0;
      quotient <= '0;
      running  <= 1'b0;
    end else if (clear) begin
      rem      <= '0;
      quotient <= '0;
      running  <= 1'b0;
    end else if (start) begin
      rem      <= dividend;
      quotient <= '0;
      running  <= 1'b1;
    end else if (running) begin
      quotient <= quotient + TIME_W'(1);
      if (done) begin
        running <= 1'b0;
      end else begin
        rem <= rem - TIME_W'(UNIT);
      end
    end
  end

endmodule

// File: rtl/parking_exit_biller.sv
// Exit-side biller: stay duration, ceiling-divided billable units, capped fee,
// payment handshake, then a timed gate opening.
module parking_exit_biller
  import parking_pkg::*;
#(
  parameter int TIME_W      = DEF_TIME_W,
  parameter int FEE_W       = DEF_FEE_W,
  parameter int UNIT        = DEF_UNIT,
  parameter int RATE        = DEF_RATE,
  parameter int FREE_TIME   = DEF_FREE_TIME,
  parameter int MAX_FEE     = DEF_MAX_FEE,
  parameter int GATE_CYCLES = DEF_GATE_CYCLES
) (
  input  logic                  clock,
  input  logic                  reset,
  parking_exit_biller_if.slave  bus,
  output state_t                state_dbg
);

  localparam int PW    = FEE_W + TIME_W;
  localparam int CNT_W = $clog2(GATE_CYCLES + 1);

  state_t            state, next_state;
  logic [TIME_W-1:0] p_q, q_q, diff, duration_r, units;
  logic [FEE_W-1:0]  fee_r, fee_calc;
  logic [PW-1:0]     product;
  logic [CNT_W-1:0]  gate_cnt;
  logic              fee_valid_r, gate_open_r, busy_r;
  logic              div_start, div_clear, div_done;

  assign diff     = q_q - p_q;
  assign product  = PW'(units) * PW'(RATE);
  assign fee_calc = (product > PW'(MAX_FEE)) ? FEE_W'(MAX_FEE) : product[FEE_W-1:0];

  fee_divider #(.TIME_W(TIME_W), .UNIT(UNIT)) u_div (
    .clock    (clock),
    .reset    (reset),
    .start    (div_start),
    .clear    (div_clear),
    .dividend (diff),
    .quotient (units),
    .done     (div_done)
  );

  always_comb begin
    next_state = state;
    div_start  = 1'b0;
    div_clear  = 1'b0;
    case (state)
      IDLE:    if (bus.checkout) next_state = DIFF;
      DIFF: begin
        if (diff <= TIME_W'(FREE_TIME)) begin
          div_clear  = 1'b1;
          next_state = MUL;
        end else begin
          div_start  = 1'b1;
          next_state = DIV;
        end
      end
      DIV:     if (div_done) next_state = MUL;
      MUL:     next_state = (fee_calc == '0) ? GATE : PRESENT;
      PRESENT: if (bus.pay_ack) next_state = GATE;
      GATE:    if (gate_cnt <= CNT_W'(1)) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Status outputs are registered copies of the upcoming state, so they line up with it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      p_q         <= '0;
      q_q         <= '0;
      duration_r  <= '0;
      fee_r       <= '0;
      gate_cnt    <= '0;
      fee_valid_r <= 1'b0;
      gate_open_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      busy_r      <= (next_state != IDLE);
      fee_valid_r <= (next_state == PRESENT);
      gate_open_r <= (next_state == GATE);
      if (state == IDLE && bus.checkout) begin
        p_q <= bus.data_P;
        q_q <= bus.data_Q;
      end
      if (state == DIFF) duration_r <= diff;
      if (state == MUL)  fee_r <= fee_calc;
      if (next_state == GATE && state != GATE) begin
        gate_cnt <= CNT_W'(GATE_CYCLES);
      end else if (state == GATE) begin
        gate_cnt <= gate_cnt - CNT_W'(1);
      end
    end
  end

  assign bus.duration  = duration_r;
  assign bus.fee       = fee_r;
  assign bus.fee_valid = fee_valid_r;
  assign bus.gate_open = gate_open_r;
  assign bus.busy      = busy_r;
  assign state_dbg     = state;

endmodule

// File: tb/tb_parking_exit_biller.sv
// Randomized bench for parking_exit_biller with an arithmetic billing model and fee scoreboard.
module tb_parking_exit_biller;
  import parking_pkg::*;

  localparam int UNIT        = 15;
  localparam int RATE        = 2;
  localparam int FREE_TIME   = 10;
  localparam int MAX_FEE     = 30;
  localparam int GATE_CYCLES = 4;

  logic   clock = 1'b0;
  logic   reset = 1'b0;
  state_t state_dbg;

  parking_exit_biller_if #(.TIME_W(8), .FEE_W(12)) bus();

  parking_exit_biller #(
    .TIME_W(8), .FEE_W(12), .UNIT(UNIT), .RATE(RATE), .FREE_TIME(FREE_TIME),
    .MAX_FEE(MAX_FEE), .GATE_CYCLES(GATE_CYCLES)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clock = ~clock;

  int tests  = 0;
  int failed = 0;
  logic [11:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int model_duration(input int p, input int q);
    return (q - p + 256) % 256;
  endfunction

  function automatic int model_units(input int p, input int q);
    int d;
    d = model_duration(p, q);
    if (d <= FREE_TIME) return 0;
    return (d + UNIT - 1) / UNIT;
  endfunction

  function automatic int model_fee(input int units);
    return (units * RATE > MAX_FEE) ? MAX_FEE : units * RATE;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_valid"}, 32'(bus.fee_valid), 0);
    check({tag, "_gate"}, 32'(bus.gate_open), 0);
  endtask

  // driver: one full checkout; noise adds ignored checkout/pay_ack pulses
  task automatic run_txn(input int p, input int q, input int hold, input bit noise);
    int dur, units, fee_m, lat, cyc, glen;
    logic [11:0] exp_fee;
    dur   = model_duration(p, q);
    units = model_units(p, q);
    fee_m = model_fee(units);
    lat   = units + 2;
    exp_q.push_back(12'(fee_m));
    bus.data_P   = 8'(p);
    bus.data_Q   = 8'(q);
    bus.checkout = 1'b1;
    bus.pay_ack  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    tick();
    bus.checkout = 1'b0;
    bus.pay_ack  = 1'b0;
    cyc = 0;
    while (!bus.fee_valid && !bus.gate_open && cyc < 400) begin
      if (noise) begin
        bus.checkout = 1'($urandom_range(0, 1));
        bus.pay_ack  = 1'($urandom_range(0, 1));
        bus.data_P   = 8'($urandom);
        bus.data_Q   = 8'($urandom);
      end
      tick();
      cyc++;
    end
    bus.checkout = 1'b0;
    bus.pay_ack  = 1'b0;
    check("latency", 32'(cyc), 32'(lat));
    check("busy", 32'(bus.busy), 1);
    check("duration", 32'(bus.duration), 32'(dur));
    exp_fee = exp_q.pop_front();
    if (fee_m > 0) begin
      check("valid_up", 32'(bus.fee_valid), 1);
      check("gate_early", 32'(bus.gate_open), 0);
      repeat (hold) begin
        if (noise) bus.checkout = 1'($urandom_range(0, 1));
        tick();
      end
      bus.checkout = 1'b0;
      check("fee_hold", 32'(bus.fee), 32'(exp_fee));
      check("valid_hold", 32'(bus.fee_valid), 1);
      check("dur_hold", 32'(bus.duration), 32'(dur));
      bus.pay_ack  = 1'b1;
      bus.checkout = noise;
      tick();
      bus.pay_ack  = 1'b0;
      bus.checkout = 1'b0;
      check("valid_drop", 32'(bus.fee_valid), 0);
    end else begin
      check("no_valid", 32'(bus.fee_valid), 0);
    end
    check("fee", 32'(bus.fee), 32'(exp_fee));
    glen = 0;
    while (bus.gate_open && glen < 50) begin
      glen++;
      if (noise) begin
        bus.checkout = 1'($urandom_range(0, 1));
        bus.pay_ack  = 1'($urandom_range(0, 1));
      end
      tick();
    end
    bus.checkout = 1'b0;
    bus.pay_ack  = 1'b0;
    check("gate_len", 32'(glen), 32'(GATE_CYCLES));
    check("busy_end", 32'(bus.busy), 0);
    check("fee_keep", 32'(bus.fee), 32'(exp_fee));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_quiet(tag);
    check({tag, "_dur"}, 32'(bus.duration), 0);
    check({tag, "_fee"}, 32'(bus.fee), 0);
    check({tag, "_state"}, 32'(state_dbg), 32'(IDLE));
  endtask

  initial begin
    int p, q, cyc;
    bus.data_P   = '0;
    bus.data_Q   = '0;
    bus.checkout = 1'b0;
    bus.pay_ack  = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    @(negedge clock);
    reset = 1'b1;
    tick();

    // directed cases
    run_txn(10, 50, 20, 1'b0);
    run_txn(250, 20, 2, 1'b1);
    run_txn(0, 255, 1, 1'b1);
    run_txn(5, 15, 0, 1'b1);
    run_txn(5, 16, 0, 1'b0);
    run_txn(7, 37, 3, 1'b1);
    run_txn(3, 3, 0, 1'b0);

    // pay_ack while idle does nothing
    bus.pay_ack = 1'b1;
    repeat (3) tick();
    bus.pay_ack = 1'b0;
    check_quiet("idle_ack");
    check("idle_ack_state", 32'(state_dbg), 32'(IDLE));

    // random cases, half near the grace boundary
    for (int i = 0; i < 14; i++) begin
      p = $urandom_range(0, 255);
      q = (i % 2 == 0) ? $urandom_range(0, 255) : (p + $urandom_range(0, 40)) % 256;
      run_txn(p, q, $urandom_range(0, 6), 1'($urandom_range(0, 1)));
    end

    // asynchronous reset while dividing
    bus.data_P   = 8'd0;
    bus.data_Q   = 8'd255;
    bus.checkout = 1'b1;
    tick();
    bus.checkout = 1'b0;
    repeat (4) tick();
    check("pre_rst_div", 32'(state_dbg), 32'(DIV));
    #2 reset = 1'b0;
    #1 check_reset_outputs("rst_div");
    @(negedge clock);
    reset = 1'b1;
    tick();

    // asynchronous reset while the gate is open
    bus.data_P   = 8'd5;
    bus.data_Q   = 8'd15;
    bus.checkout = 1'b1;
    tick();
    bus.checkout = 1'b0;
    cyc = 0;
    while (!bus.gate_open && cyc < 20) begin
      tick();
      cyc++;
    end
    tick();
    check("pre_rst_gate", 32'(bus.gate_open), 1);
    check("pre_rst_dur", 32'(bus.duration), 10);
    #2 reset = 1'b0;
    #1 check_reset_outputs("rst_gate");
    @(negedge clock);
    reset = 1'b1;
    tick();

    run_txn(0, 30, 3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
